// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Indexed by hex value; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0][3:0] digit;
  } frame_t;
endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver with anti-ghosting blanking and
// frame-synchronous value commit. Define SEVEN_SEG_LZ_BLANK_EN to suppress leading zeros.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scan_sel,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam logic [7:0] CNT_INIT = 8'(BLANK_CYCLES);

  logic [1:0] sel_q;
  logic [7:0] blank_cnt;
  frame_t     disp_q, shadow_q, in_frame;
  logic       change, frame_bnd, blank;
  logic [6:0] dec_seg, digit_seg;
  logic       lz_blank;

  assign in_frame  = {dp_in, value_in};
  assign change    = (scan_sel != sel_q);
  assign frame_bnd = (sel_q == 2'd3) && (scan_sel == 2'd0);
  assign blank     = change || (blank_cnt != 8'd0);

  hex_to_seg u_dec (
    .hex (disp_q.digit[sel_q]),
    .seg (dec_seg)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // A digit above digit0 is dark when it and every digit above it are zero.
  logic hi_zero;
  always_comb begin
    lz_blank = 1'b0;
    hi_zero  = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      hi_zero = hi_zero && (disp_q.digit[i] == 4'd0);
      if (sel_q == 2'(i) && hi_zero) lz_blank = 1'b1;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign digit_seg = lz_blank ? SEG_OFF : dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 2'd0;
      blank_cnt <= CNT_INIT;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending   <= 1'b0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      sel_q <= scan_sel;

      if (change)                  blank_cnt <= CNT_INIT;
      else if (blank_cnt != 8'd0)  blank_cnt <= blank_cnt - 8'd1;

      if (value_valid) shadow_q <= in_frame;

      // Display only changes on the 3->0 wrap so a frame never mixes two values.
      if (frame_bnd) begin
        if (value_valid)  disp_q <= in_frame;
        else if (pending) disp_q <= shadow_q;
        pending <= 1'b0;
      end else if (value_valid) begin
        pending <= 1'b1;
      end

      if (blank) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << sel_q);
        seg <= digit_seg;
        dp  <= ~disp_q.dp[sel_q];
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed scoreboard bench for seven_seg_scanner (BLANK_CYCLES = 16).
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  scan_sel;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] OFF_AN  = 4'b1111;
  localparam logic [6:0] OFF_SEG = 7'b1111111;

  seven_seg_scanner #(.BLANK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .scan_sel(scan_sel), .value_in(value_in),
    .dp_in(dp_in), .value_valid(value_valid), .pending(pending),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] bseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                            input logic ed, input logic ep);
    exp_t e;
    e.tag = tag; e.an = ea; e.seg = es; e.dp = ed; e.pend = ep;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard empty: got an=%b seg=%b", an, seg);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (an === e.an) else begin
        errors++; $error("FAIL %s an: got %b want %b", e.tag, an, e.an);
      end
      checks++;
      assert (seg === e.seg) else begin
        errors++; $error("FAIL %s seg: got %b want %b", e.tag, seg, e.seg);
      end
      checks++;
      assert (dp === e.dp) else begin
        errors++; $error("FAIL %s dp: got %b want %b", e.tag, dp, e.dp);
      end
      checks++;
      assert (pending === e.pend) else begin
        errors++; $error("FAIL %s pending: got %b want %b", e.tag, pending, e.pend);
      end
    end
  endtask

  // Change digit, wait out blanking, then check the digit shown.
  task automatic goto_chk(input string tag, input logic [1:0] d, input logic [6:0] es,
                          input logic ed, input logic ep);
    logic [3:0] ea;
    ea = ~(4'b0001 << d);
    scan_sel = d;
    expect_out(tag, ea, es, ed, ep);
    repeat (18) tick();
    check_out();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    value_valid = 1'b1; value_in = v; dp_in = d;
    tick();
    value_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; scan_sel = 2'd0; value_in = '0; dp_in = '0; value_valid = 1'b0;
    expect_out("reset", OFF_AN, OFF_SEG, 1'b1, 1'b0);
    tick(); tick();
    check_out();
    rst = 1'b0;

    // Blanking window after a digit change
    scan_sel = 2'd1;
    for (int i = 0; i < 17; i++) begin
      expect_out($sformatf("blank%0d", i), OFF_AN, OFF_SEG, 1'b1, 1'b0);
      tick();
      check_out();
    end
    expect_out("blank_end", 4'b1101, bseg(4'h0), 1'b1, 1'b0);
    tick();
    check_out();

    // Deferred load held until the frame wrap
    expect_out("defer_hold", 4'b1101, bseg(4'h0), 1'b1, 1'b1);
    load(16'h12AF, 4'b0001);
    check_out();
    goto_chk("defer_d2", 2'd2, bseg(4'h0), 1'b1, 1'b1);
    goto_chk("defer_d3", 2'd3, bseg(4'h0), 1'b1, 1'b1);
    scan_sel = 2'd0;
    expect_out("wrap_commit", OFF_AN, OFF_SEG, 1'b1, 1'b0);
    tick();
    check_out();
    expect_out("new_d0", 4'b1110, bseg(4'hF), 1'b0, 1'b0);
    repeat (17) tick();
    check_out();
    goto_chk("new_d1", 2'd1, bseg(4'hA), 1'b1, 1'b0);

    // Load coinciding with the wrap commits directly
    goto_chk("old_d2", 2'd2, bseg(4'h2), 1'b1, 1'b0);
    goto_chk("old_d3", 2'd3, bseg(4'h1), 1'b1, 1'b0);
    scan_sel = 2'd0;
    expect_out("direct_wrap", OFF_AN, OFF_SEG, 1'b1, 1'b0);
    load(16'h0008, 4'b0000);
    check_out();
    expect_out("direct_d0", 4'b1110, bseg(4'h8), 1'b1, 1'b0);
    repeat (17) tick();
    check_out();

    // Second load in a frame overwrites the first
    goto_chk("ow_d1", 2'd1, bseg(4'h0), 1'b1, 1'b0);
    load(16'h1111, 4'b0000);
    expect_out("ow_pend", 4'b1101, bseg(4'h0), 1'b1, 1'b1);
    load(16'h2222, 4'b0000);
    check_out();
    goto_chk("ow_d2", 2'd2, bseg(4'h0), 1'b1, 1'b1);
    goto_chk("ow_d3", 2'd3, bseg(4'h0), 1'b1, 1'b1);
    goto_chk("ow_new_d0", 2'd0, bseg(4'h2), 1'b1, 1'b0);
    goto_chk("ow_new_d1", 2'd1, bseg(4'h2), 1'b1, 1'b0);

    // Leading-zero handling
    load(16'h0050, 4'b0000);
    goto_chk("lz_pre_d2", 2'd2, bseg(4'h2), 1'b1, 1'b1);
    goto_chk("lz_pre_d3", 2'd3, bseg(4'h2), 1'b1, 1'b1);
    goto_chk("lz_d0", 2'd0, bseg(4'h0), 1'b1, 1'b0);
    goto_chk("lz_d1", 2'd1, bseg(4'h5), 1'b1, 1'b0);
    goto_chk("lz_d2", 2'd2, LZ ? OFF_SEG : bseg(4'h0), 1'b1, 1'b0);
    goto_chk("lz_d3", 2'd3, LZ ? OFF_SEG : bseg(4'h0), 1'b1, 1'b0);

    // Reset mid-frame abandons the pending value
    expect_out("rst_pend", 4'b0111, LZ ? OFF_SEG : bseg(4'h0), 1'b1, 1'b1);
    load(16'h1234, 4'b1111);
    check_out();
    rst = 1'b1; scan_sel = 2'd0;
    expect_out("rst_mid", OFF_AN, OFF_SEG, 1'b1, 1'b0);
    tick();
    check_out();
    rst = 1'b0;
    expect_out("rst_blank", OFF_AN, OFF_SEG, 1'b1, 1'b0);
    repeat (16) tick();
    check_out();
    expect_out("rst_d0", 4'b1110, bseg(4'h0), 1'b1, 1'b0);
    tick();
    check_out();
    goto_chk("rst_d1", 2'd1, bseg(4'h0), 1'b1, 1'b0);
    goto_chk("rst_d2", 2'd2, bseg(4'h0), 1'b1, 1'b0);
    goto_chk("rst_d3", 2'd3, bseg(4'h0), 1'b1, 1'b0);
    goto_chk("rst_wrap_d0", 2'd0, bseg(4'h0), 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
